// File: rtl/via_pkg.sv
// Shared field layout helpers for the via_m_n dependency point.
// A flit is packed MSB first as src, dst, id, data.
package via_pkg;

  localparam int unsigned ID_W = 8;

  // Width of the payload data field left after the routing header.
  function automatic int unsigned cw_of(input int unsigned width, input int unsigned naw);
    return width - 2 * naw - ID_W;
  endfunction

  function automatic int unsigned data_off();
    return 0;
  endfunction

  function automatic int unsigned id_off(input int unsigned width, input int unsigned naw);
    return cw_of(width, naw);
  endfunction

  function automatic int unsigned dst_off(input int unsigned width, input int unsigned naw);
    return cw_of(width, naw) + ID_W;
  endfunction

  function automatic int unsigned src_off(input int unsigned width, input int unsigned naw);
    return cw_of(width, naw) + ID_W + naw;
  endfunction

  // Location of the shared traffic trace written by the simulation model.
  function automatic string trace_path();
    return "reports/lynx_trace.txt";
  endfunction

endpackage

// File: rtl/via_token_fifo.sv
// Per-sink flit buffer: pointer-based FIFO with an explicit 0..DEPTH occupancy count.
module via_token_fifo #(
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned CNTW = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic [DW-1:0]   data_in,
  output logic [DW-1:0]   data_out,
  output logic [CNTW-1:0] count,
  output logic            full,
  output logic            empty
);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full     = (count == CNTW'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign data_out = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= data_in;
  end

  // DEPTH is a power of two, so the pointers wrap by overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + CNTW'(1);
      else if (do_pop && !do_push) count <= count - CNTW'(1);
    end
  end

endmodule

// File: rtl/via_m_n.sv
// NUM_IN-sink / NUM_OUT-source dependency point: all sources fire together once
// every sink holds a flit (or NODEP) and every source is ready.
module via_m_n
  import via_pkg::*;
#(
  parameter int unsigned NUM_IN       = 2,
  parameter int unsigned NUM_OUT      = 2,
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned N            = 16,
  parameter int unsigned N_ADDR_WIDTH = $clog2(N),
  parameter int unsigned NODE         = 15,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned MAX_DEST     = 4,
  parameter logic [NUM_OUT*8-1:0] O_NUM_DEST = {NUM_OUT{8'd4}},
  parameter logic [NUM_OUT*MAX_DEST*N_ADDR_WIDTH-1:0] O_DEST =
    {(NUM_OUT*MAX_DEST){N_ADDR_WIDTH'(1)}},
  parameter logic [NUM_OUT*8-1:0] O_ID  = '0,
  parameter logic [NUM_IN*8-1:0]  I_ID  = '0,
  parameter bit                   NODEP = 1'b0,
  parameter int unsigned          DONE_COUNT = 1000
) (
  input  logic                              clk,
  input  logic                              rst,
  output logic                              done,
  input  logic [NUM_IN*WIDTH-1:0]           i_data_in,
  input  logic [NUM_IN-1:0]                 i_valid_in,
  output logic [NUM_IN-1:0]                 i_ready_out,
  output logic [NUM_OUT*WIDTH-1:0]          o_data_out,
  output logic [NUM_OUT*N_ADDR_WIDTH-1:0]   o_dest_out,
  output logic [NUM_OUT-1:0]                o_valid_out,
  input  logic [NUM_OUT-1:0]                o_ready_in
);

  localparam int unsigned NAW  = N_ADDR_WIDTH;
  localparam int unsigned CW   = cw_of(WIDTH, N_ADDR_WIDTH);
  localparam int unsigned DOFF = data_off();
  localparam int unsigned PW   = (MAX_DEST > 1) ? $clog2(MAX_DEST) : 1;
  localparam int unsigned CNTW = $clog2(DEPTH + 1);

  logic [NUM_IN-1:0]  push;
  logic [NUM_IN-1:0]  pop;
  logic [NUM_IN-1:0]  full;
  logic [NUM_IN-1:0]  empty;
  logic [NUM_IN-1:0]  nonempty;
  logic               fire;
  logic               done_nxt;

  logic [CW-1:0]      last_rx     [NUM_IN];
  logic [CW-1:0]      last_rx_nxt [NUM_IN];
  logic [CW-1:0]      head_unused [NUM_IN];
  logic [CNTW-1:0]    count_unused [NUM_IN];

  logic [CW-1:0]      cnt      [NUM_OUT];
  logic [CW-1:0]      cnt_nxt  [NUM_OUT];
  logic [PW-1:0]      ptr      [NUM_OUT];
  logic [PW-1:0]      ptr_nxt  [NUM_OUT];
  logic [NAW-1:0]     dest_sel [NUM_OUT];
  logic [WIDTH-1:0]   data_r   [NUM_OUT];
  logic [NAW-1:0]     dest_r   [NUM_OUT];

  // Header bits of incoming flits and buffered heads are not consumed here.
  logic sink_unused;
  assign sink_unused = ^{I_ID, i_data_in, 32'(N)};

  for (genvar k = 0; k < NUM_IN; k++) begin : g_sink
    via_token_fifo #(.DW(CW), .DEPTH(DEPTH)) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (push[k]),
      .pop      (pop[k]),
      .data_in  (i_data_in[k*WIDTH+DOFF +: CW]),
      .data_out (head_unused[k]),
      .count    (count_unused[k]),
      .full     (full[k]),
      .empty    (empty[k])
    );
    assign nonempty[k] = !empty[k];
  end

  for (genvar j = 0; j < NUM_OUT; j++) begin : g_src
    assign o_data_out[j*WIDTH +: WIDTH] = data_r[j];
    assign o_dest_out[j*NAW +: NAW]     = dest_r[j];
  end

  // Handshake, fire decision and next values of the per-channel bookkeeping.
  always_comb begin
    i_ready_out = '0;
    push        = '0;
    pop         = '0;
    fire        = ((&nonempty) || NODEP) && (&o_ready_in);
    done_nxt    = 1'b1;
    for (int k = 0; k < NUM_IN; k++) begin
      i_ready_out[k] = !rst && !full[k];
      push[k]        = i_valid_in[k] && i_ready_out[k];
      pop[k]         = fire && nonempty[k];
      last_rx_nxt[k] = push[k] ? i_data_in[k*WIDTH+DOFF +: CW] : last_rx[k];
      if (!NODEP && !(64'(last_rx_nxt[k]) > 64'(DONE_COUNT))) done_nxt = 1'b0;
    end
    for (int j = 0; j < NUM_OUT; j++) begin
      dest_sel[j] = O_DEST[(j*MAX_DEST + 32'(ptr[j]))*NAW +: NAW];
      cnt_nxt[j]  = cnt[j];
      ptr_nxt[j]  = ptr[j];
      if (fire) begin
        cnt_nxt[j] = cnt[j] + CW'(1);
        if (32'(ptr[j]) + 32'd1 >= 32'(O_NUM_DEST[j*8 +: 8])) ptr_nxt[j] = '0;
        else                                                  ptr_nxt[j] = ptr[j] + PW'(1);
      end
      if (!(64'(cnt_nxt[j]) > 64'(DONE_COUNT))) done_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_valid_out <= '0;
      done        <= 1'b0;
      for (int k = 0; k < NUM_IN; k++) last_rx[k] <= '0;
      for (int j = 0; j < NUM_OUT; j++) begin
        cnt[j]    <= '0;
        ptr[j]    <= '0;
        dest_r[j] <= '0;
        data_r[j] <= {NAW'(NODE), NAW'(0), O_ID[j*8 +: 8], CW'(0)};
      end
    end else begin
      o_valid_out <= {NUM_OUT{fire}};
      done        <= done_nxt;
      for (int k = 0; k < NUM_IN; k++) last_rx[k] <= last_rx_nxt[k];
      for (int j = 0; j < NUM_OUT; j++) begin
        cnt[j] <= cnt_nxt[j];
        ptr[j] <= ptr_nxt[j];
        if (fire) begin
          dest_r[j] <= dest_sel[j];
          data_r[j] <= {NAW'(NODE), dest_sel[j], O_ID[j*8 +: 8], cnt_nxt[j]};
        end
      end
    end
  end

endmodule

// File: tb/tb_via_m_n.sv
// Randomized bench for via_m_n: a 2x2 instance with sink dependencies and a
// 1x1 NODEP instance with a narrow counter, both checked against queue models.
module tb_via_m_n;

  localparam int unsigned WA  = 32;
  localparam int unsigned DEP = 4;
  localparam int unsigned DCA = 5;
  localparam logic [31:0] DEST_A = 32'h8765_4321;
  localparam logic [15:0] NUMD_A = {8'd3, 8'd4};
  localparam logic [15:0] ID_A   = {8'hB2, 8'hA1};
  localparam int unsigned WB  = 20;
  localparam int unsigned DCB = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_a, rst_b;
  logic          done_a, done_b;
  logic [63:0]   din_a;
  logic [1:0]    vin_a, rdy_a, vout_a, ordy_a;
  logic [63:0]   dout_a;
  logic [7:0]    dst_a;
  logic [19:0]   din_b, dout_b;
  logic          vin_b, rdy_b, vout_b, ordy_b;
  logic [3:0]    dst_b;

  via_m_n #(
    .NUM_IN(2), .NUM_OUT(2), .WIDTH(WA), .N(16), .NODE(15), .DEPTH(DEP), .MAX_DEST(4),
    .O_NUM_DEST(NUMD_A), .O_DEST(DEST_A), .O_ID(ID_A), .I_ID(16'h0201),
    .NODEP(1'b0), .DONE_COUNT(DCA)
  ) dut_a (
    .clk(clk), .rst(rst_a), .done(done_a),
    .i_data_in(din_a), .i_valid_in(vin_a), .i_ready_out(rdy_a),
    .o_data_out(dout_a), .o_dest_out(dst_a), .o_valid_out(vout_a), .o_ready_in(ordy_a)
  );

  via_m_n #(
    .NUM_IN(1), .NUM_OUT(1), .WIDTH(WB), .N(16), .NODE(15), .DEPTH(DEP), .MAX_DEST(2),
    .O_NUM_DEST(8'd2), .O_DEST(8'h93), .O_ID(8'h5C), .I_ID(8'h00),
    .NODEP(1'b1), .DONE_COUNT(DCB)
  ) dut_b (
    .clk(clk), .rst(rst_b), .done(done_b),
    .i_data_in(din_b), .i_valid_in(vin_b), .i_ready_out(rdy_b),
    .o_data_out(dout_b), .o_dest_out(dst_b), .o_valid_out(vout_b), .o_ready_in(ordy_b)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference state: sink queues, counters and destination indices.
  int          q_a [2][$];
  int          last_a [2];
  int          cnt_a [2];
  int          ptr_a [2];
  logic [1:0]  ev_a;
  logic [31:0] ed_a [2];
  logic [3:0]  edst_a [2];
  logic        edone_a;
  int          cnt_b, ptr_b;
  logic        ev_b, edone_b;
  logic [19:0] ed_b;
  logic [3:0]  edst_b;

  function automatic int dest_a(input int j, input int e);
    logic [31:0] t;
    t = DEST_A >> ((j * 4 + e) * 4);
    return int'(t[3:0]);
  endfunction

  function automatic int num_a(input int j);
    logic [15:0] t;
    t = NUMD_A >> (j * 8);
    return int'(t[7:0]);
  endfunction

  function automatic logic [31:0] flit_a(input int j, input int d, input int c);
    logic [15:0] t;
    t = ID_A >> (j * 8);
    return (32'd15 << 28) | (32'(d) << 24) | (32'(t[7:0]) << 16) | 32'(c);
  endfunction

  function automatic logic [19:0] flit_b(input int d, input int c);
    return (20'd15 << 16) | (20'(d) << 12) | (20'h5C << 4) | 20'(c);
  endfunction

  task automatic step_a();
    bit fire, allne, pushk;
    if (rst_a) begin
      for (int k = 0; k < 2; k++) begin q_a[k].delete(); last_a[k] = 0; end
      for (int j = 0; j < 2; j++) begin
        cnt_a[j] = 0; ptr_a[j] = 0; ed_a[j] = flit_a(j, 0, 0); edst_a[j] = 0;
      end
      ev_a = 2'b00; edone_a = 1'b0;
    end else begin
      allne = 1;
      for (int k = 0; k < 2; k++) if (q_a[k].size() == 0) allne = 0;
      fire = allne && (ordy_a == 2'b11);
      for (int k = 0; k < 2; k++) begin
        pushk = vin_a[k] && (q_a[k].size() != DEP);
        if (fire) void'(q_a[k].pop_front());
        if (pushk) begin
          q_a[k].push_back(int'(din_a[k*32 +: 16]));
          last_a[k] = int'(din_a[k*32 +: 16]);
        end
      end
      for (int j = 0; j < 2; j++) if (fire) begin
        cnt_a[j]  = (cnt_a[j] + 1) % 65536;
        edst_a[j] = 4'(dest_a(j, ptr_a[j]));
        ed_a[j]   = flit_a(j, dest_a(j, ptr_a[j]), cnt_a[j]);
        ptr_a[j]  = (ptr_a[j] + 1) % num_a(j);
      end
      ev_a = fire ? 2'b11 : 2'b00;
      edone_a = (cnt_a[0] > DCA) && (cnt_a[1] > DCA) && (last_a[0] > DCA) && (last_a[1] > DCA);
    end
  endtask

  task automatic step_b();
    if (rst_b) begin
      cnt_b = 0; ptr_b = 0; ev_b = 0; ed_b = flit_b(0, 0); edst_b = 0; edone_b = 0;
    end else begin
      ev_b = ordy_b;
      if (ordy_b) begin
        cnt_b  = (cnt_b + 1) % 16;
        edst_b = (ptr_b == 0) ? 4'd3 : 4'd9;
        ed_b   = flit_b(int'(edst_b), cnt_b);
        ptr_b  = (ptr_b + 1) % 2;
      end
      edone_b = cnt_b > DCB;
    end
  endtask

  // Drive one cycle of stimulus, check ready before the edge and outputs after it.
  task automatic cycle(input logic ra, input logic [1:0] va, input logic [63:0] da,
                       input logic [1:0] oa, input logic rb, input logic ob);
    logic [1:0] er;
    rst_a = ra; vin_a = va; din_a = da; ordy_a = oa;
    rst_b = rb; ordy_b = ob;
    #1;
    for (int k = 0; k < 2; k++) er[k] = !ra && (q_a[k].size() != DEP);
    check("a_ready", 64'(rdy_a), 64'(er));
    check("b_ready", 64'(rdy_b), 64'(!rb));
    step_a();
    step_b();
    @(posedge clk);
    #1;
    check("a_valid", 64'(vout_a), 64'(ev_a));
    check("a_data0", 64'(dout_a[31:0]), 64'(ed_a[0]));
    check("a_data1", 64'(dout_a[63:32]), 64'(ed_a[1]));
    check("a_dest",  64'(dst_a), 64'({edst_a[1], edst_a[0]}));
    check("a_done",  64'(done_a), 64'(edone_a));
    check("b_valid", 64'(vout_b), 64'(ev_b));
    check("b_data",  64'(dout_b), 64'(ed_b));
    check("b_dest",  64'(dst_b), 64'(edst_b));
    check("b_done",  64'(done_b), 64'(edone_b));
  endtask

  function automatic logic [63:0] rnd_flits();
    logic [31:0] f0, f1;
    f0 = $urandom; f1 = $urandom;
    if ($urandom_range(0, 1) == 0) f0[15:0] = 16'($urandom_range(0, 12));
    if ($urandom_range(0, 1) == 0) f1[15:0] = 16'($urandom_range(0, 12));
    return {f1, f0};
  endfunction

  initial begin
    logic [1:0] oa;
    din_b = '0; vin_b = 1'b0;
    repeat (3) cycle(1'b1, 2'b00, 64'd0, 2'b00, 1'b1, 1'b0);
    // Idle after reset, then a lone sink-0 flit must not fire.
    repeat (2) cycle(1'b0, 2'b00, 64'd0, 2'b11, 1'b0, 1'b1);
    cycle(1'b0, 2'b01, rnd_flits(), 2'b11, 1'b0, 1'b1);
    cycle(1'b0, 2'b00, 64'd0, 2'b11, 1'b0, 1'b1);
    cycle(1'b0, 2'b10, rnd_flits(), 2'b11, 1'b0, 1'b1);
    repeat (2) cycle(1'b0, 2'b00, 64'd0, 2'b11, 1'b0, 1'b1);
    // Fill both FIFOs while blocked, then drain.
    repeat (5) cycle(1'b0, 2'b11, rnd_flits(), 2'b00, 1'b0, 1'b1);
    repeat (6) cycle(1'b0, 2'b00, 64'd0, 2'b11, 1'b0, 1'b1);
    // Reset with flits buffered; nothing may fire afterwards.
    repeat (2) cycle(1'b0, 2'b11, rnd_flits(), 2'b00, 1'b0, 1'b1);
    cycle(1'b1, 2'b00, 64'd0, 2'b00, 1'b0, 1'b1);
    repeat (3) cycle(1'b0, 2'b00, 64'd0, 2'b11, 1'b0, 1'b1);
    for (int i = 0; i < 400; i++) begin
      oa[0] = ($urandom_range(0, 3) != 0);
      oa[1] = ($urandom_range(0, 3) != 0);
      cycle(($urandom_range(0, 63) == 0), 2'($urandom), rnd_flits(), oa,
            ($urandom_range(0, 99) == 0), ($urandom_range(0, 7) != 0));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
